// File: rtl/rsa_load_sequencer.sv
// Operand/result sequencer for the RSA core: streams latched operands LSW-first to the core,
// kicks it, waits for completion with a timeout, then gathers the result word-by-word.
module rsa_load_sequencer #(
  parameter int RSA_LEN = 512,
  parameter int BUS_W   = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          crt,
  input  logic [RSA_LEN-1:0]            mod_in,
  input  logic [RSA_LEN/2-1:0]          pre_in,
  input  logic [RSA_LEN-1:0]            exp_in,
  input  logic [RSA_LEN-1:0]            msg_in,
  output logic                          busy,
  output logic                          wr_en,
  output logic [1:0]                    wr_sel,
  output logic [$clog2(RSA_LEN/BUS_W)-1:0] wr_idx,
  output logic [BUS_W-1:0]              wr_data,
  output logic                          core_start,
  input  logic                          core_done,
  output logic                          rd_en,
  output logic [$clog2(RSA_LEN/BUS_W)-1:0] rd_idx,
  input  logic [BUS_W-1:0]              rd_data,
  output logic [RSA_LEN-1:0]            res_out,
  output logic                          done,
  output logic                          err
);

  localparam int NW = RSA_LEN / BUS_W;
  localparam int IW = $clog2(NW);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LD_MOD = 4'd1;
  localparam logic [3:0] S_LD_PRE = 4'd2;
  localparam logic [3:0] S_LD_EXP = 4'd3;
  localparam logic [3:0] S_LD_MSG = 4'd4;
  localparam logic [3:0] S_KICK   = 4'd5;
  localparam logic [3:0] S_WAIT   = 4'd6;
  localparam logic [3:0] S_UNLOAD = 4'd7;
  localparam logic [3:0] S_FIN    = 4'd8;

  localparam logic [15:0] LAST_FULL = 16'(NW - 1);
  localparam logic [15:0] LAST_HALF = 16'(NW / 2 - 1);
  localparam logic [15:0] TMO       = 16'(TIMEOUT);

  logic [3:0]             state_reg;
  logic [15:0]            cnt_reg;
  logic                   crt_reg;
  logic                   err_reg;
  logic [RSA_LEN-1:0]     mod_sr;
  logic [RSA_LEN/2-1:0]   pre_sr;
  logic [RSA_LEN-1:0]     exp_sr;
  logic [RSA_LEN-1:0]     msg_sr;
  logic [RSA_LEN-1:0]     res_reg;
  logic [IW-1:0]          cnt_idx;

  assign cnt_idx = cnt_reg[IW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      crt_reg   <= 1'b0;
      err_reg   <= 1'b0;
      mod_sr    <= '0;
      pre_sr    <= '0;
      exp_sr    <= '0;
      msg_sr    <= '0;
      res_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            mod_sr    <= mod_in;
            pre_sr    <= pre_in;
            exp_sr    <= exp_in;
            msg_sr    <= msg_in;
            crt_reg   <= crt;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= S_LD_MOD;
          end
        end
        // Each load phase shifts its operand so the next word is always in the low slot.
        S_LD_MOD: begin
          mod_sr <= mod_sr >> BUS_W;
          if (cnt_reg == LAST_FULL) begin
            cnt_reg   <= '0;
            state_reg <= crt_reg ? S_LD_PRE : S_LD_EXP;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        S_LD_PRE: begin
          pre_sr <= pre_sr >> BUS_W;
          if (cnt_reg == LAST_HALF) begin
            cnt_reg   <= '0;
            state_reg <= S_LD_EXP;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        S_LD_EXP: begin
          exp_sr <= exp_sr >> BUS_W;
          if (cnt_reg == LAST_FULL) begin
            cnt_reg   <= '0;
            state_reg <= S_LD_MSG;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        S_LD_MSG: begin
          msg_sr <= msg_sr >> BUS_W;
          if (cnt_reg == LAST_FULL) begin
            cnt_reg   <= '0;
            state_reg <= S_KICK;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        S_KICK: begin
          cnt_reg   <= '0;
          state_reg <= S_WAIT;
        end
        // core_done is checked first so a completion on the last allowed cycle still wins.
        S_WAIT: begin
          if (core_done) begin
            cnt_reg   <= '0;
            state_reg <= S_UNLOAD;
          end else if (cnt_reg == TMO) begin
            cnt_reg   <= '0;
            err_reg   <= 1'b1;
            state_reg <= S_FIN;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        S_UNLOAD: begin
          res_reg[BUS_W*cnt_idx +: BUS_W] <= rd_data;
          if (cnt_reg == LAST_FULL) begin
            cnt_reg   <= '0;
            state_reg <= S_FIN;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        S_FIN: begin
          state_reg <= S_IDLE;
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_sel  = 2'd0;
    wr_data = '0;
    case (state_reg)
      S_LD_MOD: begin wr_en = 1'b1; wr_sel = 2'd0; wr_data = mod_sr[BUS_W-1:0]; end
      S_LD_PRE: begin wr_en = 1'b1; wr_sel = 2'd1; wr_data = pre_sr[BUS_W-1:0]; end
      S_LD_EXP: begin wr_en = 1'b1; wr_sel = 2'd2; wr_data = exp_sr[BUS_W-1:0]; end
      S_LD_MSG: begin wr_en = 1'b1; wr_sel = 2'd3; wr_data = msg_sr[BUS_W-1:0]; end
      default: ;
    endcase
  end

  assign busy       = (state_reg != S_IDLE);
  assign wr_idx     = wr_en ? cnt_idx : '0;
  assign core_start = (state_reg == S_KICK);
  assign rd_en      = (state_reg == S_UNLOAD);
  assign rd_idx     = rd_en ? cnt_idx : '0;
  assign done       = (state_reg == S_FIN);
  assign err        = err_reg;
  assign res_out    = res_reg;

endmodule

// File: tb/tb_rsa_load_sequencer.sv
// Directed bench for rsa_load_sequencer: a vector table of whole operations plus
// hand-written reset-abort sequences, with a small core model answering start/read.
module tb_rsa_load_sequencer;

  localparam int RSA_LEN = 512;
  localparam int BUS_W   = 32;
  localparam int NW      = 16;
  localparam int TO      = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start, crt, core_done;
  logic [RSA_LEN-1:0]   mod_in, exp_in, msg_in;
  logic [RSA_LEN/2-1:0] pre_in;
  logic                 busy, wr_en, core_start, rd_en, done, err;
  logic [1:0]           wr_sel;
  logic [3:0]           wr_idx, rd_idx;
  logic [BUS_W-1:0]     wr_data, rd_data;
  logic [RSA_LEN-1:0]   res_out;
  logic [15:0]          seed;

  // Core result word depends on a per-run seed and the requested index.
  assign rd_data = {seed, 12'h000, rd_idx} ^ 32'h9E37_79B9;

  rsa_load_sequencer #(.RSA_LEN(RSA_LEN), .BUS_W(BUS_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .crt(crt),
    .mod_in(mod_in), .pre_in(pre_in), .exp_in(exp_in), .msg_in(msg_in),
    .busy(busy), .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data),
    .core_start(core_start), .core_done(core_done),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data),
    .res_out(res_out), .done(done), .err(err)
  );

  typedef struct {
    logic        crt;
    int          delay;     // cycles from core_start to core_done, -1 = never
    logic        disturb;   // pulse start and scramble inputs mid-operation
    logic [15:0] seed;
    int          cs_off;
    int          done_off;
    logic        err;
    int          nwr;
    int          nrd;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [1:0]  sel;
    logic [3:0]  idx;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[7];
  wr_t  wlog[$];
  int   cyc, due, cur_delay;
  int   cs_cyc, cs_n, done_cyc, done_n, rd_n, rd_bad;
  logic done_err;
  int   passed, total;
  logic [RSA_LEN-1:0] prev_res;

  task automatic chk(input string name, input logic [RSA_LEN-1:0] act, input logic [RSA_LEN-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (wr_en) wlog.push_back('{cyc, wr_sel, wr_idx, wr_data});
    if (core_start) begin
      cs_n++;
      cs_cyc = cyc;
      if (cur_delay >= 0) due = cyc + cur_delay;
    end
    core_done = (cyc == due);
    if (rd_en) begin
      if (rd_idx != 4'(rd_n)) rd_bad++;
      rd_n++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
      done_err = err;
    end
  endtask

  task automatic clear_log();
    wlog.delete();
    due = -1; cs_cyc = -1; cs_n = 0; done_cyc = -1; done_n = 0;
    rd_n = 0; rd_bad = 0; done_err = 1'b0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NW; i++) begin
      mod_in[32*i +: 32] = $urandom;
      exp_in[32*i +: 32] = $urandom;
      msg_in[32*i +: 32] = $urandom;
    end
    for (int i = 0; i < NW/2; i++) pre_in[32*i +: 32] = $urandom;
  endtask

  function automatic logic [RSA_LEN-1:0] res_model(input logic [15:0] s);
    logic [RSA_LEN-1:0] r;
    for (int i = 0; i < NW; i++) r[32*i +: 32] = {s, 12'h000, 4'(i)} ^ 32'h9E37_79B9;
    return r;
  endfunction

  function automatic logic [47:0] outs_vec();
    return {busy, wr_en, wr_sel, wr_idx, wr_data, core_start, rd_en, rd_idx, done, err};
  endfunction

  task automatic run_vec(input vec_t v, input int n);
    logic [RSA_LEN-1:0]   m_s, e_s, g_s, exp_res;
    logic [RSA_LEN/2-1:0] p_s;
    logic [255:0]         pre_pat;
    int t0, k, bad;
    rand_inputs();
    pre_pat = {4{64'h0123_4567_89ab_cdef}};
    if (v.crt) pre_in = pre_pat;
    m_s = mod_in; p_s = pre_in; e_s = exp_in; g_s = msg_in;
    seed = v.seed;
    cur_delay = v.delay;
    clear_log();
    step();
    t0 = cyc; start = 1'b1; crt = v.crt;
    step();
    start = 1'b0; crt = ~v.crt;
    chk($sformatf("v%0d_busy_t1", n), busy, 1'b1);
    while (done_n == 0 && cyc < t0 + 400) begin
      if (v.disturb && (cyc == t0 + 20 || cyc == t0 + 55)) begin
        start = 1'b1;
        rand_inputs();
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    chk($sformatf("v%0d_done_seen", n), done_n, 1);
    chk($sformatf("v%0d_kick_cycle", n), cs_cyc - t0, v.cs_off);
    chk($sformatf("v%0d_kick_count", n), cs_n, 1);
    chk($sformatf("v%0d_done_cycle", n), done_cyc - t0, v.done_off);
    chk($sformatf("v%0d_err", n), done_err, v.err);
    chk($sformatf("v%0d_nwrites", n), wlog.size(), v.nwr);
    chk($sformatf("v%0d_nreads", n), rd_n, v.nrd);
    chk($sformatf("v%0d_rd_idx_seq", n), rd_bad, 0);
    // Expected write stream: MOD, [PRE], EXP, MSG, back-to-back from T+1.
    bad = 0; k = 0;
    for (int ph = 0; ph < 4; ph++) begin
      int nw;
      if (ph == 1 && !v.crt) continue;
      nw = (ph == 1) ? NW/2 : NW;
      for (int i = 0; i < nw; i++) begin
        logic [31:0] w;
        case (ph)
          0: w = m_s[32*i +: 32];
          1: w = p_s[32*i +: 32];
          2: w = e_s[32*i +: 32];
          default: w = g_s[32*i +: 32];
        endcase
        if (k >= wlog.size() || wlog[k].cyc != t0 + 1 + k || wlog[k].sel != 2'(ph) ||
            wlog[k].idx != 4'(i) || wlog[k].data != w) bad++;
        k++;
      end
    end
    chk($sformatf("v%0d_write_stream", n), bad, 0);
    exp_res = v.err ? prev_res : res_model(v.seed);
    chk($sformatf("v%0d_res_out", n), res_out, exp_res);
    prev_res = exp_res;
    step();
    chk($sformatf("v%0d_idle_after", n), busy, 1'b0);
    chk($sformatf("v%0d_err_held", n), err, v.err);
    $display("vec %0d crt=%0d delay=%0d kick@T+%0d done@T+%0d err=%0d writes=%0d reads=%0d",
             n, v.crt, v.delay, cs_cyc - t0, done_cyc - t0, done_err, wlog.size(), rd_n);
  endtask

  task automatic rst_abort(input int at_off, input string tag);
    int t0;
    rand_inputs();
    seed = 16'h00AA;
    cur_delay = 10;
    clear_log();
    step();
    t0 = cyc; start = 1'b1; crt = 1'b0;
    step();
    start = 1'b0;
    while (cyc < t0 + at_off) step();
    if (at_off > 60) chk({tag, "_in_unload"}, rd_en, 1'b1);
    else chk({tag, "_in_ld_msg"}, {wr_en, wr_sel}, 3'b111);
    rst = 1'b1;
    step();
    chk({tag, "_outputs_zero"}, outs_vec(), 48'h0);
    chk({tag, "_res_zero"}, res_out, '0);
    rst = 1'b0;
    done_n = 0;
    repeat (150) step();
    chk({tag, "_no_done"}, done_n, 0);
    prev_res = '0;
    $display("reset abort %s at T+%0d", tag, at_off);
  endtask

  initial begin
    passed = 0; total = 0; cyc = 0; prev_res = '0;
    rst = 1'b1; start = 1'b0; crt = 1'b0; core_done = 1'b0;
    mod_in = '0; pre_in = '0; exp_in = '0; msg_in = '0; seed = '0;
    cur_delay = -1;
    clear_log();

    vecs[0] = '{1'b0, 10,  1'b0, 16'h0001, 49,  76, 1'b0, 48, 16};
    vecs[1] = '{1'b1, 10,  1'b0, 16'h0002, 57,  84, 1'b0, 56, 16};
    vecs[2] = '{1'b0, -1,  1'b0, 16'h0003, 49, 151, 1'b1, 48,  0};
    vecs[3] = '{1'b0, 10,  1'b1, 16'h0004, 49,  76, 1'b0, 48, 16};
    vecs[4] = '{1'b0, 101, 1'b0, 16'h0005, 49, 167, 1'b0, 48, 16};
    vecs[5] = '{1'b1, 0,   1'b0, 16'h0006, 57, 159, 1'b1, 56,  0};
    vecs[6] = '{1'b0, 1,   1'b0, 16'h0007, 49,  67, 1'b0, 48, 16};

    repeat (3) step();
    rst = 1'b0;
    chk("reset_outputs", outs_vec(), 48'h0);
    chk("reset_res", res_out, '0);
    step();
    chk("idle_no_start", busy, 1'b0);

    for (int n = 0; n < 7; n++) run_vec(vecs[n], n);

    rst_abort(40, "rst_ld_msg");
    rst_abort(65, "rst_unload");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
